full_flag_calc: RTL and testbench
=================================

FULL_FLAG_CALC -- requirements
Module: full_flag_calc

Interface
REQ-001 SHALL have parameter ADDR, default 4, meaning address width (DEPTH = 2^ADDR entries); legal range ADDR >= 2.
REQ-002 SHALL have parameter AFULL_MARGIN, default 2, meaning almost_full asserts when free entries <= AFULL_MARGIN; legal range 1..DEPTH-1.
REQ-003 SHALL have port wr_clk  input  1  write-domain clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write request from producer.
REQ-006 SHALL have port sync_rd_ptr  input  ADDR+1  gray read pointer, already synchronized into wr_clk.
REQ-007 SHALL have port wr_add  output  ADDR  memory write address, binary pointer without MSB.
REQ-008 SHALL have port gr_wr_ptr  output  ADDR+1  registered gray write pointer, for synchronization to the read domain.
REQ-009 SHALL have port full_flag  output  1  registered full indication.
REQ-010 SHALL have port almost_full  output  1  registered almost-full indication.
REQ-011 SHALL have port wr_ack  output  1  one-cycle pulse, write accepted on the previous edge.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse, write attempted while full on the previous edge.
REQ-013 SHALL have port wr_count  output  ADDR+1  registered fill level seen from the write side, 0..DEPTH.

Function
REQ-014 SHALL accept a write on a wr_clk edge iff wr_en=1 and full_flag=0; wr_add then names the slot written in that cycle.
REQ-015 SHALL hold an ADDR+1-bit binary write pointer, incremented by 1 on each accepted write, wrapping 2^(ADDR+1)-1 -> 0.
REQ-016 SHALL drive wr_add = binary pointer[ADDR-1:0] and gr_wr_ptr = registered gray(binary pointer); both change on the same edge.
REQ-017 SHALL compute next pointer P' = pointer + accepted, and register full_flag = (gray(P') == {~sync_rd_ptr[ADDR:ADDR-1], sync_rd_ptr[ADDR-2:0]}).
REQ-018 SHALL therefore assert full_flag on the same edge as the write that fills entry DEPTH; a wr_en in the next cycle is refused.
REQ-019 SHALL re-evaluate full_flag every edge, including with no write: it deasserts on the first edge after sync_rd_ptr advances.
REQ-020 SHALL convert sync_rd_ptr to binary R and register wr_count = (P' - R) mod 2^(ADDR+1).
REQ-021 SHALL register almost_full = (wr_count_next >= DEPTH - AFULL_MARGIN); full implies almost_full.
REQ-022 SHALL register wr_ack = wr_en & ~full_flag, and overflow = wr_en & full_flag; never both high.
REQ-023 SHALL leave the pointer, wr_add and gr_wr_ptr unchanged on refused writes.
REQ-024 SHALL treat a simultaneous accepted write and read-pointer advance as net zero fill change; full stays deasserted.
REQ-025 SHALL add no latency beyond one register stage on any output.

Reset
REQ-026 SHALL, while rst=0, force pointer=0, wr_add=0, gr_wr_ptr=0, full_flag=0, almost_full=0, wr_ack=0, overflow=0, wr_count=0, asynchronously.
REQ-027 SHALL resume on the first wr_clk edge after rst deasserts; reset mid-write discards that write (no wr_ack).
REQ-028 SHALL need rst released synchronously to wr_clk by the integration level; no internal synchronizer.

Structure
REQ-029 SHALL take the ADDR default and the DEPTH = 1<<ADDR derivation from the shared FIFO parameter header also used by the read side.
REQ-030 SHALL instantiate one sub-module gray2bin (parameter W = ADDR+1, purely combinational), reusable by the read-side flag logic.
REQ-031 SHALL keep binary-to-gray conversion inline (P ^ (P >> 1)).

Verification (ADDR=4, DEPTH=16, AFULL_MARGIN=2, sync_rd_ptr held 0 unless stated)
REQ-032 SHALL cover reset: rst=0 with wr_en=1 -> all outputs 0; after release, first edge with wr_en=1 -> wr_ack=1, wr_add=1, gr_wr_ptr=5'b00001.
REQ-033 SHALL cover fill: 16 back-to-back writes -> almost_full rises after write 14, full_flag rises with write 16, wr_count=16, gr_wr_ptr=5'b11000.
REQ-034 SHALL cover overflow: wr_en=1 while full -> overflow=1, wr_ack=0, wr_add and gr_wr_ptr unchanged, wr_count=16.
REQ-035 SHALL cover drain release: while full, set sync_rd_ptr=5'b00001 -> full_flag=0 next edge, wr_count=15; write then accepted, full reasserts.
REQ-036 SHALL cover wrap: cycle 40 writes with sync_rd_ptr tracking gray(ptr-1) -> wr_count=1, full never set, pointer wraps 31 -> 0 with gr_wr_ptr 5'b10000 -> 5'b00000.
REQ-037 SHALL cover mid-operation reset: rst=0 at fill 9 -> outputs 0 immediately; after release, refill to 16 behaves as REQ-033.

Source files
------------

// File: rtl/full_flag_calc_pkg.sv
// -----------------------------------------------------------------------------
// full_flag_calc_pkg
// Shared FIFO parameter header. The write-side flag logic (full_flag_calc) and
// the read-side flag logic both take the default address width and the depth
// derivation from here, so both sides always agree on the FIFO geometry.
// Contents:
//   FIFO_ADDR   - default address width (DEPTH = 2**FIFO_ADDR entries)
//   fifo_depth  - derives the entry count from an address width
// -----------------------------------------------------------------------------
package full_flag_calc_pkg;

    localparam int FIFO_ADDR = 4;

    function automatic int fifo_depth(input int addr);
        return 1 << addr;
    endfunction

endpackage

// File: rtl/full_flag_calc_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter. Shared by the write-side full
// logic and the read-side empty logic.
// Ports:
//   gray - W-bit Gray-coded value
//   bin  - W-bit binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/full_flag_calc.sv
// -----------------------------------------------------------------------------
// full_flag_calc
// Write-domain pointer and flag logic of an asynchronous FIFO. Holds the
// binary write pointer, publishes its Gray form for the read domain, and
// produces registered full / almost-full / fill-level / handshake outputs
// from the read pointer already synchronized into wr_clk.
// Ports:
//   wr_clk      - write-domain clock, all state on the rising edge
//   rst         - asynchronous active-low reset (released synchronously
//                 by the integration level)
//   wr_en       - write request from the producer
//   sync_rd_ptr - Gray read pointer, already synchronized into wr_clk
//   wr_add      - memory write address (binary pointer without its MSB)
//   gr_wr_ptr   - registered Gray write pointer for the read domain
//   full_flag   - registered full indication
//   almost_full - registered almost-full indication
//   wr_ack      - one-cycle pulse: a write was accepted on the previous edge
//   overflow    - one-cycle pulse: a write was refused because of full
//   wr_count    - registered fill level seen from the write side, 0..DEPTH
// -----------------------------------------------------------------------------
module full_flag_calc
    import full_flag_calc_pkg::*;
#(
    parameter int ADDR         = FIFO_ADDR,
    parameter int AFULL_MARGIN = 2
) (
    input  logic            wr_clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [ADDR:0]   sync_rd_ptr,
    output logic [ADDR-1:0] wr_add,
    output logic [ADDR:0]   gr_wr_ptr,
    output logic            full_flag,
    output logic            almost_full,
    output logic            wr_ack,
    output logic            overflow,
    output logic [ADDR:0]   wr_count
);

    localparam int DEPTH = fifo_depth(ADDR);
    localparam logic [ADDR:0] AFULL_THRESH = (ADDR+1)'(DEPTH - AFULL_MARGIN);

    logic [ADDR:0] wr_ptr;
    logic [ADDR:0] wr_ptr_next;
    logic [ADDR:0] gray_next;
    logic [ADDR:0] full_pattern;
    logic [ADDR:0] rd_bin;
    logic [ADDR:0] wr_count_next;
    logic          accepted;
    logic          full_next;
    logic          almost_full_next;

    gray2bin #(
        .W (ADDR + 1)
    ) u_rd_gray2bin (
        .gray (sync_rd_ptr),
        .bin  (rd_bin)
    );

    // Next-state view of the write side. The flags are computed from the
    // pointer as it will be after this edge, so full asserts together with
    // the write that fills the last entry and a write in the following cycle
    // is already refused. The FIFO is full when the write pointer has lapped
    // the read pointer exactly once: in Gray code that means the top two bits
    // differ and the rest match.
    always_comb begin
        accepted         = wr_en & ~full_flag;
        wr_ptr_next      = wr_ptr + {{ADDR{1'b0}}, accepted};
        gray_next        = wr_ptr_next ^ (wr_ptr_next >> 1);
        full_pattern     = {~sync_rd_ptr[ADDR:ADDR-1], sync_rd_ptr[ADDR-2:0]};
        full_next        = (gray_next == full_pattern);
        wr_count_next    = wr_ptr_next - rd_bin;
        almost_full_next = (wr_count_next >= AFULL_THRESH);
    end

    // Single register stage for the pointer and every output flag.
    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            gr_wr_ptr   <= '0;
            full_flag   <= 1'b0;
            almost_full <= 1'b0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
            wr_count    <= '0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            gr_wr_ptr   <= gray_next;
            full_flag   <= full_next;
            almost_full <= almost_full_next;
            wr_ack      <= accepted;
            overflow    <= wr_en & full_flag;
            wr_count    <= wr_count_next;
        end
    end

    assign wr_add = wr_ptr[ADDR-1:0];

endmodule

// File: tb/tb_full_flag_calc.sv
// -----------------------------------------------------------------------------
// tb_full_flag_calc
// Directed self-checking bench for full_flag_calc with ADDR=4 (DEPTH=16) and
// AFULL_MARGIN=2. Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_full_flag_calc;

    logic       wr_clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] sync_rd_ptr = '0;
    logic [3:0] wr_add;
    logic [4:0] gr_wr_ptr;
    logic       full_flag;
    logic       almost_full;
    logic       wr_ack;
    logic       overflow;
    logic [4:0] wr_count;

    int checks = 0;
    int errors = 0;

    full_flag_calc #(
        .ADDR         (4),
        .AFULL_MARGIN (2)
    ) dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .sync_rd_ptr (sync_rd_ptr),
        .wr_add      (wr_add),
        .gr_wr_ptr   (gr_wr_ptr),
        .full_flag   (full_flag),
        .almost_full (almost_full),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .wr_count    (wr_count)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Put the block into the empty state with the read pointer at zero.
    task automatic do_reset();
        wr_en       = 1'b0;
        sync_rd_ptr = '0;
        rst         = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        wr_en       = 1'b1;
        sync_rd_ptr = '0;
        tick();
        tick();
        checks += 7;
        if (wr_add !== 4'd0) begin errors++; $display("[TB] FAIL reset_wr_add actual=%0d required=0", wr_add); end
        if (gr_wr_ptr !== 5'b00000) begin errors++; $display("[TB] FAIL reset_gr_wr_ptr actual=%b required=00000", gr_wr_ptr); end
        if (full_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_full actual=%b required=0", full_flag); end
        if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost_full actual=%b required=0", almost_full); end
        if (wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ack actual=%b required=0", wr_ack); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow actual=%b required=0", overflow); end
        if (wr_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_wr_count actual=%0d required=0", wr_count); end
        rst = 1'b1;
        tick();
        checks += 4;
        if (wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL first_wr_ack actual=%b required=1", wr_ack); end
        if (wr_add !== 4'd1) begin errors++; $display("[TB] FAIL first_wr_add actual=%0d required=1", wr_add); end
        if (gr_wr_ptr !== 5'b00001) begin errors++; $display("[TB] FAIL first_gr_wr_ptr actual=%b required=00001", gr_wr_ptr); end
        if (wr_count !== 5'd1) begin errors++; $display("[TB] FAIL first_wr_count actual=%0d required=1", wr_count); end
        wr_en = 1'b0;
    endtask

    // 16 back-to-back writes from empty; used by the fill and mid-reset tests.
    task automatic fill_sixteen(input string tag);
        wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks += 4;
            if (wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL %s_wr_ack[%0d] actual=%b required=1", tag, i, wr_ack); end
            if (wr_count !== 5'(i)) begin errors++; $display("[TB] FAIL %s_wr_count[%0d] actual=%0d required=%0d", tag, i, wr_count, i); end
            if (almost_full !== (i >= 14)) begin errors++; $display("[TB] FAIL %s_almost_full[%0d] actual=%b required=%b", tag, i, almost_full, (i >= 14)); end
            if (full_flag !== (i == 16)) begin errors++; $display("[TB] FAIL %s_full[%0d] actual=%b required=%b", tag, i, full_flag, (i == 16)); end
        end
        wr_en = 1'b0;
        checks += 2;
        if (gr_wr_ptr !== 5'b11000) begin errors++; $display("[TB] FAIL %s_gr_wr_ptr actual=%b required=11000", tag, gr_wr_ptr); end
        if (wr_add !== 4'd0) begin errors++; $display("[TB] FAIL %s_wr_add actual=%0d required=0", tag, wr_add); end
    endtask

    task automatic test_fill();
        do_reset();
        fill_sixteen("fill");
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks += 6;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_overflow actual=%b required=1", overflow); end
        if (wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL ovf_wr_ack actual=%b required=0", wr_ack); end
        if (wr_add !== 4'd0) begin errors++; $display("[TB] FAIL ovf_wr_add actual=%0d required=0", wr_add); end
        if (gr_wr_ptr !== 5'b11000) begin errors++; $display("[TB] FAIL ovf_gr_wr_ptr actual=%b required=11000", gr_wr_ptr); end
        if (wr_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_wr_count actual=%0d required=16", wr_count); end
        if (full_flag !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full actual=%b required=1", full_flag); end
        tick();
        checks += 1;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pulse_end actual=%b required=0", overflow); end
    endtask

    task automatic test_drain_release();
        sync_rd_ptr = 5'b00001;
        tick();
        checks += 3;
        if (full_flag !== 1'b0) begin errors++; $display("[TB] FAIL drain_full actual=%b required=0", full_flag); end
        if (wr_count !== 5'd15) begin errors++; $display("[TB] FAIL drain_wr_count actual=%0d required=15", wr_count); end
        if (almost_full !== 1'b1) begin errors++; $display("[TB] FAIL drain_almost_full actual=%b required=1", almost_full); end
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks += 5;
        if (wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL refill_wr_ack actual=%b required=1", wr_ack); end
        if (full_flag !== 1'b1) begin errors++; $display("[TB] FAIL refill_full actual=%b required=1", full_flag); end
        if (wr_count !== 5'd16) begin errors++; $display("[TB] FAIL refill_wr_count actual=%0d required=16", wr_count); end
        if (gr_wr_ptr !== 5'b11001) begin errors++; $display("[TB] FAIL refill_gr_wr_ptr actual=%b required=11001", gr_wr_ptr); end
        if (wr_add !== 4'd1) begin errors++; $display("[TB] FAIL refill_wr_add actual=%0d required=1", wr_add); end
    endtask

    // The reader keeps up with the writer, so the fill level stays at one
    // while the pointer laps its full 5-bit range.
    task automatic test_wrap();
        logic [4:0] ptr;
        do_reset();
        ptr   = '0;
        wr_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            sync_rd_ptr = to_gray(ptr);
            tick();
            ptr = ptr + 5'd1;
            checks += 4;
            if (wr_count !== 5'd1) begin errors++; $display("[TB] FAIL wrap_wr_count[%0d] actual=%0d required=1", i, wr_count); end
            if (full_flag !== 1'b0) begin errors++; $display("[TB] FAIL wrap_full[%0d] actual=%b required=0", i, full_flag); end
            if (wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL wrap_wr_ack[%0d] actual=%b required=1", i, wr_ack); end
            if (gr_wr_ptr !== to_gray(ptr)) begin errors++; $display("[TB] FAIL wrap_gr_wr_ptr[%0d] actual=%b required=%b", i, gr_wr_ptr, to_gray(ptr)); end
            if (i == 31) begin
                checks++;
                if (gr_wr_ptr !== 5'b10000) begin errors++; $display("[TB] FAIL wrap_gray31 actual=%b required=10000", gr_wr_ptr); end
            end
            if (i == 32) begin
                checks += 2;
                if (gr_wr_ptr !== 5'b00000) begin errors++; $display("[TB] FAIL wrap_gray0 actual=%b required=00000", gr_wr_ptr); end
                if (wr_add !== 4'd0) begin errors++; $display("[TB] FAIL wrap_wr_add0 actual=%0d required=0", wr_add); end
            end
        end
        wr_en = 1'b0;
    endtask

    // A write accepted on the same edge the read pointer advances leaves the
    // fill level at 15 and must not raise full.
    task automatic test_back_to_back();
        do_reset();
        wr_en = 1'b1;
        for (int i = 1; i <= 15; i++) tick();
        sync_rd_ptr = to_gray(5'd1);
        tick();
        wr_en = 1'b0;
        checks += 4;
        if (wr_count !== 5'd15) begin errors++; $display("[TB] FAIL simul_wr_count actual=%0d required=15", wr_count); end
        if (full_flag !== 1'b0) begin errors++; $display("[TB] FAIL simul_full actual=%b required=0", full_flag); end
        if (wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL simul_wr_ack actual=%b required=1", wr_ack); end
        if (almost_full !== 1'b1) begin errors++; $display("[TB] FAIL simul_almost_full actual=%b required=1", almost_full); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr_en = 1'b1;
        for (int i = 1; i <= 9; i++) tick();
        checks += 1;
        if (wr_count !== 5'd9) begin errors++; $display("[TB] FAIL mid_pre_count actual=%0d required=9", wr_count); end
        rst = 1'b0;
        #1;
        checks += 4;
        if (wr_count !== 5'd0) begin errors++; $display("[TB] FAIL mid_async_count actual=%0d required=0", wr_count); end
        if (wr_add !== 4'd0) begin errors++; $display("[TB] FAIL mid_async_wr_add actual=%0d required=0", wr_add); end
        if (gr_wr_ptr !== 5'b00000) begin errors++; $display("[TB] FAIL mid_async_gr_wr_ptr actual=%b required=00000", gr_wr_ptr); end
        if (wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_wr_ack actual=%b required=0", wr_ack); end
        tick();
        checks += 1;
        if (wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_discard_wr_ack actual=%b required=0", wr_ack); end
        wr_en = 1'b0;
        rst   = 1'b1;
        fill_sixteen("refill");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
